unidade_multdiv: RTL and testbench
==================================

Name: unidade_multdiv

Overview:
- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair, so the single-cycle ALU does not need combinational 64-bit multiply or 32-bit divide paths.
- Accepts an operation from the control unit with a start/busy/done handshake and runs an iterative shift-add multiply or restoring divide over 32 cycles.
- Applies sign correction, then writes HI/LO.
- Also services move-to-HI/LO writes and supplies HI/LO for move-from reads.

Parameters:
- WIDTH, 32: operand width; HI/LO are WIDTH each.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00 multu, 01 mult, 10 divu, 11 div
- in1  in  WIDTH  multiplicand / dividend
- in2  in  WIDTH  multiplier / divisor
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wdata  in  WIDTH  data for mthi/mtlo
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when HI/LO receive a new result
- div_zero  out  1  sticky flag; set by a divide with in2 == 0, cleared by the next accepted start
- hi  out  WIDTH  HI register (product upper word / remainder)
- lo  out  WIDTH  LO register (product lower word / quotient)

Behaviour:
- Reset (synchronous, highest priority, honoured in any state):
  - state = IDLE, counter = 0.
  - hi = lo = 0, busy = done = div_zero = 0.
  - Any operation in flight is abandoned with no HI/LO write.
- States: IDLE, CALC, FIX.
- IDLE:
  - If start = 1 (edge T0): latch op.
  - Latch magnitudes of in1/in2: absolute value for op 01/11, raw value for 00/10.
  - Record the result signs:
    - product sign = in1[31] ^ in2[31]
    - quotient sign = in1[31] ^ in2[31]
    - remainder sign = in1[31]
  - Clear div_zero and counter, then go to CALC.
  - Exception: a divide with in2 == 0 goes directly to FIX with the div-zero path selected.
- CALC: one iteration per edge, 32 edges (T0+1..T0+32). At the edge with counter == 31, go to FIX.
  - Multiply: 65-bit accumulator {carry, P[63:32]}, P[31:0] = multiplier. If P[0] = 1, add the multiplicand to the upper half. Then shift the whole 65 bits right by 1.
  - Divide: shift {R, Q} left by 1 and compute R - divisor in WIDTH+1 bits. If the result is non-negative, R = difference and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
- FIX, one edge (T0+33; T0+1 for div-zero):
  - Signed ops: negate results per the recorded signs (two's complement).
  - Multiply: {hi, lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Div-zero: hi = in1 as latched (raw), lo = all ones, div_zero = 1.
  - done = 1 for this one cycle; state goes to IDLE.
- Latency:
  - Result and done are visible in the cycle after edge T0+33; for div-zero, in the cycle after T0+1.
  - busy is high in the cycles after T0 through T0+32 and is low in the done cycle.
  - A new start is accepted in the same cycle done is high.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - hi_we/lo_we while busy: ignored.
  - hi_we/lo_we in IDLE with start = 0: hi/lo = wdata at that edge; done is not pulsed.
  - hi_we/lo_we together with start = 1 in IDLE: start wins, the write is dropped.
  - Signed div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no flag.
  - Signed mult/div with the 0x80000000 operand: its magnitude is 0x80000000, correct in WIDTH-bit unsigned.
  - in1/in2 may change after T0 without effect.
  - hi/lo hold their values during CALC; the old values are readable until the FIX write.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF, start at T0 -> busy high for 33 cycles; done only in the cycle after T0+33; hi = 0xFFFFFFFE, lo = 0x00000001.
- mult -3 × 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; repeat the same operands as multu -> hi = 0x00000006, lo = 0xFFFFFFEB.
- divu 100 / 7 -> lo = 0x0000000E, hi = 0x00000002; div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- divu 5 / 0 -> done in the cycle after T0+1; div_zero = 1, hi = 5, lo = 0xFFFFFFFF; the next mult start clears div_zero.
- Busy-state conflicts:
  - Pulse start with different operands and hi_we with 0x12345678 at T0+5 -> both ignored; the final result matches the first operation.
  - Assert reset at T0+10 -> the next cycle shows busy = 0, hi = lo = 0, done = 0; a new start runs a full 33-cycle operation correctly.
- In IDLE:
  - hi_we = 1, wdata = 0x12345678 -> hi = 0x12345678 next cycle, no done.
  - lo_we together with start -> the write is dropped and the operation is launched.

Source files
------------

// File: rtl/unidade_multdiv_if.sv
// Handshake and HI/LO access bundle between the control unit and the
// multiply/divide sequencer.
interface unidade_multdiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/unidade_multdiv.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; services mthi/mtlo writes
// CALC  | one shift-add (mul) or restoring (div) iteration per edge, WIDTH edges
// FIX   | sign correction and HI/LO write, pulses done next cycle
module unidade_multdiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clock,
  input logic             reset,
  unidade_multdiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               dz_q;
  logic               neg_main;   // sign of product or quotient
  logic               neg_rem;    // sign of remainder
  logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] wk;         // {P_hi, P_lo} for mul, {R, Q} for div
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_flag_q;

  logic               launch, step, finish;
  logic               launch_dz;
  logic [WIDTH-1:0]   mag1, mag2;

  logic [WIDTH:0]     sum_hi;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Signed ops work on magnitudes; 0x80000000 maps onto itself, which is
  // still the right unsigned magnitude.
  assign mag1 = (bus.op[0] && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
  assign mag2 = (bus.op[0] && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
  assign launch_dz = bus.op[1] && (bus.in2 == '0);

  // Shift-add step: the carry out of the upper-half add only lives for the
  // cycle, since the right shift always leaves the top bit clear.
  assign sum_hi  = {1'b0, wk[2*WIDTH-1:WIDTH]} + (wk[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {sum_hi, wk[WIDTH-1:1]};

  // Restoring step: R < divisor holds, so the WIDTH+1 bit sign of the
  // difference is a reliable borrow.
  assign partial = {wk[2*WIDTH-1:WIDTH], wk[WIDTH-1]};
  assign diff    = partial - {1'b0, opnd};
  assign rem_new = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign div_nxt = {rem_new, wk[WIDTH-2:0], ~diff[WIDTH]};

  assign prod_fix = neg_main ? -wk : wk;
  assign quo_fix  = neg_main ? -wk[WIDTH-1:0] : wk[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -wk[2*WIDTH-1:WIDTH] : wk[2*WIDTH-1:WIDTH];

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_flag_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state datapath strobes.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          launch    = 1'b1;
          state_nxt = launch_dz ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      end
      FIX: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, result write and mthi/mtlo.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      op_q      <= '0;
      dz_q      <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      opnd      <= '0;
      wk        <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (launch) begin
        op_q      <= bus.op;
        dz_q      <= launch_dz;
        neg_main  <= bus.op[0] & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
        neg_rem   <= bus.op[0] & bus.in1[WIDTH-1];
        dz_flag_q <= 1'b0;
        cnt       <= '0;
        opnd      <= bus.op[1] ? mag2 : mag1;
        // On divide-by-zero the raw dividend rides in wk until FIX.
        if (launch_dz)      wk <= {{WIDTH{1'b0}}, bus.in1};
        else if (bus.op[1]) wk <= {{WIDTH{1'b0}}, mag1};
        else                wk <= {{WIDTH{1'b0}}, mag2};
      end else if (step) begin
        cnt <= cnt + 1'b1;
        wk  <= op_q[1] ? div_nxt : mul_nxt;
      end else if (finish) begin
        if (dz_q) begin
          hi_q      <= wk[WIDTH-1:0];
          lo_q      <= '1;
          dz_flag_q <= 1'b1;
        end else if (op_q[1]) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end else if (state == IDLE) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

endmodule

// File: tb/tb_unidade_multdiv.sv
// Randomized and directed bench for unidade_multdiv against a 64-bit
// arithmetic reference.
module tb_unidade_multdiv;

  logic clock = 1'b0;
  logic reset = 1'b1;

  unidade_multdiv_if #(.WIDTH(32)) bus ();

  unidade_multdiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int busy_n = 0;

  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;
  int          exp_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.busy) busy_n++;
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign, as the unit does.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_dz  = 1'b0;
    exp_lat = 34;
    case (o)
      2'd0: begin
        up = {32'd0, a} * {32'd0, b};
        {exp_hi, exp_lo} = up;
      end
      2'd1: begin
        p = sa * sb;
        {exp_hi, exp_lo} = p;
      end
      default: begin
        if (b == 32'd0) begin
          exp_hi  = a;
          exp_lo  = 32'hFFFF_FFFF;
          exp_dz  = 1'b1;
          exp_lat = 2;
        end else if (o == 2'd2) begin
          exp_lo = a / b;
          exp_hi = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          exp_lo = q[31:0];
          exp_hi = r[31:0];
        end
      end
    endcase
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    model(o, a, b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.in1   = a;
    bus.in2   = b;
    cyc       = 0;
    busy_n    = 0;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.in1   = $urandom;
    bus.in2   = $urandom;
  endtask

  task automatic finish_op(input string tag);
    while (!bus.done && cyc < 60) tick();
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    chk({tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({tag, " div_zero"}, 64'(bus.div_zero), 64'(exp_dz));
    tick();
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    launch(o, a, b);
    finish_op(tag);
  endtask

  initial begin
    logic [31:0] old_hi, ra, rb;
    logic [1:0]  ro;
    bus.start = 1'b0; bus.op = 2'd0; bus.in1 = '0; bus.in2 = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst dz", 64'(bus.div_zero), 64'd0);
    chk("rst hi", 64'(bus.hi), 64'd0);
    chk("rst lo", 64'(bus.lo), 64'd0);

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    run_op("mult_m3x7", 2'd1, 32'hFFFF_FFFD, 32'd7);
    chk("mult_m3x7 lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    run_op("multu_m3x7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    chk("multu_m3x7 hi_const", 64'(bus.hi), 64'd6);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7);
    run_op("div_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_min_m1 lo_const", 64'(bus.lo), 64'h0000_0000_8000_0000);
    run_op("mult_min", 2'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("divu_5_0", 2'd2, 32'd5, 32'd0);
    run_op("mult_clr_dz", 2'd1, 32'd12, 32'hFFFF_FFFB);

    // start and mthi while busy are both ignored
    launch(2'd2, 32'd1000, 32'd33);
    old_hi = bus.hi;
    repeat (4) tick();
    bus.start = 1'b1; bus.op = 2'd0; bus.in1 = 32'd9; bus.in2 = 32'd9;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("busy_conflict hi_held", 64'(bus.hi), 64'(old_hi));
    finish_op("busy_conflict");

    // reset mid-operation abandons it
    launch(2'd1, 32'd77, 32'd88);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst done", 64'(bus.done), 64'd0);
    chk("midrst hi", 64'(bus.hi), 64'd0);
    chk("midrst lo", 64'(bus.lo), 64'd0);
    run_op("after_rst", 2'd1, 32'd77, 32'd88);

    // mthi in IDLE
    bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
    tick();
    bus.hi_we = 1'b0;
    chk("mthi hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi no_done", 64'(bus.done), 64'd0);
    bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    tick();
    bus.lo_we = 1'b0;
    chk("mtlo lo", 64'(bus.lo), 64'hCAFE_F00D);

    // mtlo together with start: start wins
    bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    launch(2'd0, 32'd3, 32'd5);
    chk("mtlo_start busy", 64'(bus.busy), 64'd1);
    chk("mtlo_start lo_dropped", 64'(bus.lo), 64'hCAFE_F00D);
    finish_op("mtlo_start");

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
